// File: rtl/harness_pkg.sv
// Shared types and trace-entry layout for the regfile scan checker harness.
// A trace entry is packed as {cycle stamp, register index, write data}.
package harness_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RUN        = 3'd1,
        SCAN_ISSUE = 3'd2,
        SCAN_CMP   = 3'd3,
        DONE       = 3'd4
    } state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_CYC_W  = 16;
    localparam int TRACE_W    = DEF_CYC_W + DEF_ADDR_W + DEF_DATA_W;

    function automatic int trace_width(input int cyc_w, input int addr_w, input int data_w);
        return cyc_w + addr_w + data_w;
    endfunction

    function automatic int trace_reg_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int trace_cyc_lsb(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO for writeback trace entries; head is read straight from storage,
// so a push into an empty FIFO becomes visible on the following cycle.
module trace_fifo
    import harness_pkg::*;
#(
    parameter int WIDTH = TRACE_W,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ZERO = {(AW + 1){1'b0}};
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push_s;
    logic             do_pop_s;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o   = (wptr_q == rptr_q);
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);
    assign rdata_o   = mem_q[rptr_q[AW-1:0]];

    // Next-state pointers; flush wins over any push or pop in the same cycle
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = PTR_ZERO;
            rptr_d = PTR_ZERO;
        end else begin
            if (do_push_s) begin
                wptr_d = wptr_q + PTR_ONE;
            end else begin
                wptr_d = wptr_q;
            end
            if (do_pop_s) begin
                rptr_d = rptr_q + PTR_ONE;
            end else begin
                rptr_d = rptr_q;
            end
        end
    end

    // Pointer registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= PTR_ZERO;
            rptr_q <= PTR_ZERO;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Entry storage
    always_ff @(posedge clk_i) begin
        if (do_push_s && !flush_i) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/regfile_scan_checker.sv
// Processor test harness: traces register writebacks for a cycle budget, then
// takes over a regfile read port and checks every register against an expected ROM.
module regfile_scan_checker
    import harness_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int NUM_REGS    = 32,
    parameter int ADDR_W      = $clog2(NUM_REGS),
    parameter int CYC_W       = DEF_CYC_W,
    parameter int TRACE_DEPTH = 16,
    parameter int SKIP_R0     = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CYC_W-1:0]  num_cycles,
    input  logic              rwe,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] rdata,
    output logic              test_mode,
    output logic [ADDR_W-1:0] scan_addr,
    input  logic [DATA_W-1:0] scan_data,
    output logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [CYC_W-1:0]  trace_cycle,
    output logic [ADDR_W-1:0] trace_reg,
    output logic [DATA_W-1:0] trace_data,
    output logic              trace_overflow,
    output logic              err_valid,
    output logic [ADDR_W-1:0] err_reg,
    output logic [DATA_W-1:0] err_exp,
    output logic [DATA_W-1:0] err_act,
    output logic [ADDR_W:0]   error_count,
    output logic              done,
    output logic              pass
);

    localparam int TW      = trace_width(CYC_W, ADDR_W, DATA_W);
    localparam int REG_LSB = trace_reg_lsb(DATA_W);
    localparam int CYC_LSB = trace_cyc_lsb(ADDR_W, DATA_W);

    localparam logic [CYC_W-1:0]  CYC_ZERO = {CYC_W{1'b0}};
    localparam logic [CYC_W-1:0]  CYC_ONE  = CYC_W'(1);
    localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W:0]   ERR_ZERO = {(ADDR_W + 1){1'b0}};
    localparam logic [ADDR_W:0]   ERR_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   ERR_MAX  = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    state_e            state_q;
    logic [CYC_W-1:0]  budget_q;
    logic [CYC_W-1:0]  cyc_q;
    logic [ADDR_W-1:0] idx_q;
    logic              test_mode_q;
    logic              err_valid_q;
    logic [ADDR_W-1:0] err_reg_q;
    logic [DATA_W-1:0] err_exp_q;
    logic [DATA_W-1:0] err_act_q;
    logic [ADDR_W:0]   err_cnt_q;
    logic              done_q;
    logic              pass_q;
    logic              ovf_q;

    logic              start_ok_s;
    logic              log_s;
    logic              pop_s;
    logic              mismatch_s;
    logic [ADDR_W:0]   err_cnt_nxt_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [TW-1:0]     entry_s;
    logic [TW-1:0]     head_s;

    assign entry_s = {cyc_q, rd, rdata};

    // Handshake decode, write-logging filter and comparator
    always_comb begin
        start_ok_s    = 1'b0;
        log_s         = 1'b0;
        mismatch_s    = 1'b0;
        err_cnt_nxt_s = err_cnt_q;
        pop_s         = trace_ready && !fifo_empty_s;
        if (start && ((state_q == IDLE) || (state_q == DONE))) begin
            start_ok_s = 1'b1;
        end else begin
            start_ok_s = 1'b0;
        end
        if ((state_q == RUN) && rwe && !((SKIP_R0 != 0) && (rd == IDX_ZERO))) begin
            log_s = 1'b1;
        end else begin
            log_s = 1'b0;
        end
        // Exact 4-state compare so an X/Z on either side is reported as a mismatch.
        if ((state_q == SCAN_CMP) && (exp_data !== scan_data)) begin
            mismatch_s = 1'b1;
            if (err_cnt_q != ERR_MAX) begin
                err_cnt_nxt_s = err_cnt_q + ERR_ONE;
            end else begin
                err_cnt_nxt_s = err_cnt_q;
            end
        end else begin
            mismatch_s    = 1'b0;
            err_cnt_nxt_s = err_cnt_q;
        end
    end

    trace_fifo #(
        .WIDTH (TW),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .flush_i (start_ok_s),
        .push_i  (log_s),
        .wdata_i (entry_s),
        .pop_i   (trace_ready),
        .rdata_o (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Run/scan sequencing, cycle and scan counters, and all registered status outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            budget_q    <= CYC_ZERO;
            cyc_q       <= CYC_ZERO;
            idx_q       <= IDX_ZERO;
            test_mode_q <= 1'b0;
            err_valid_q <= 1'b0;
            err_reg_q   <= IDX_ZERO;
            err_exp_q   <= DATA_ZERO;
            err_act_q   <= DATA_ZERO;
            err_cnt_q   <= ERR_ZERO;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            err_valid_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start_ok_s) begin
                        budget_q  <= num_cycles;
                        cyc_q     <= CYC_ZERO;
                        idx_q     <= IDX_ZERO;
                        err_cnt_q <= ERR_ZERO;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                        ovf_q     <= 1'b0;
                        if (num_cycles == CYC_ZERO) begin
                            state_q     <= SCAN_ISSUE;
                            test_mode_q <= 1'b1;
                        end else begin
                            state_q     <= RUN;
                            test_mode_q <= 1'b0;
                        end
                    end else begin
                        state_q <= state_q;
                    end
                end
                RUN: begin
                    if (log_s && fifo_full_s && !pop_s) begin
                        ovf_q <= 1'b1;
                    end else begin
                        ovf_q <= ovf_q;
                    end
                    if (cyc_q == (budget_q - CYC_ONE)) begin
                        state_q     <= SCAN_ISSUE;
                        test_mode_q <= 1'b1;
                        idx_q       <= IDX_ZERO;
                    end else begin
                        cyc_q <= cyc_q + CYC_ONE;
                    end
                end
                SCAN_ISSUE: begin
                    state_q <= SCAN_CMP;
                end
                SCAN_CMP: begin
                    if (mismatch_s) begin
                        err_valid_q <= 1'b1;
                        err_reg_q   <= idx_q;
                        err_exp_q   <= exp_data;
                        err_act_q   <= scan_data;
                    end else begin
                        err_valid_q <= 1'b0;
                    end
                    err_cnt_q <= err_cnt_nxt_s;
                    if (idx_q == IDX_LAST) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_nxt_s == ERR_ZERO);
                    end else begin
                        idx_q   <= idx_q + IDX_ONE;
                        state_q <= SCAN_ISSUE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    test_mode_q <= 1'b0;
                end
            endcase
        end
    end

    assign test_mode      = test_mode_q;
    assign scan_addr      = idx_q;
    assign exp_addr       = idx_q;
    assign trace_valid    = !fifo_empty_s;
    assign trace_data     = head_s[DATA_W-1:0];
    assign trace_reg      = head_s[REG_LSB +: ADDR_W];
    assign trace_cycle    = head_s[CYC_LSB +: CYC_W];
    assign trace_overflow = ovf_q;
    assign err_valid      = err_valid_q;
    assign err_reg        = err_reg_q;
    assign err_exp        = err_exp_q;
    assign err_act        = err_act_q;
    assign error_count    = err_cnt_q;
    assign done           = done_q;
    assign pass           = pass_q;

endmodule

// File: tb/tb_regfile_scan_checker.sv
// Scoreboard bench: a time-indexed reference model predicts trace contents, error
// pulses and status levels; a negedge monitor compares whatever the DUT presents.
module tb_regfile_scan_checker;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int CW = 16;
    localparam int TD = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] num_cycles;
    logic          rwe;
    logic [AW-1:0] rd;
    logic [DW-1:0] rdata;
    logic          test_mode;
    logic [AW-1:0] scan_addr;
    logic [DW-1:0] scan_data;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          trace_valid;
    logic          trace_ready;
    logic [CW-1:0] trace_cycle;
    logic [AW-1:0] trace_reg;
    logic [DW-1:0] trace_data;
    logic          trace_overflow;
    logic          err_valid;
    logic [AW-1:0] err_reg;
    logic [DW-1:0] err_exp;
    logic [DW-1:0] err_act;
    logic [AW:0]   error_count;
    logic          done;
    logic          pass;

    logic [DW-1:0] regs [NR];
    logic [DW-1:0] rom  [NR];

    int checks = 0;
    int errors = 0;

    regfile_scan_checker #(.TRACE_DEPTH(TD)) dut (
        .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
        .rwe(rwe), .rd(rd), .rdata(rdata), .test_mode(test_mode),
        .scan_addr(scan_addr), .scan_data(scan_data), .exp_addr(exp_addr),
        .exp_data(exp_data), .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_cycle(trace_cycle), .trace_reg(trace_reg), .trace_data(trace_data),
        .trace_overflow(trace_overflow), .err_valid(err_valid), .err_reg(err_reg),
        .err_exp(err_exp), .err_act(err_act), .error_count(error_count),
        .done(done), .pass(pass)
    );

    always #5 clock = ~clock;

    // Regfile read port is combinational; the expected ROM has one cycle of latency.
    assign scan_data = regs[scan_addr];
    always @(posedge clock) exp_data <= rom[exp_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_t counts cycles since the accepted start.
    typedef struct { int cyc; int r; logic [DW-1:0] d; } tr_t;
    typedef struct { int r; logic [DW-1:0] e; logic [DW-1:0] a; } er_t;
    tr_t m_fifo[$];
    er_t m_errq[$];
    bit  m_active;
    bit  m_ovf;
    int  m_t, m_n, m_err;

    always @(posedge clock or negedge reset) begin
        bit busy;
        int i;
        if (!reset) begin
            m_active = 0; m_ovf = 0; m_t = 0; m_n = 0; m_err = 0;
            m_fifo.delete();
            m_errq.delete();
        end else begin
            busy = m_active && (m_t < m_n + 2 * NR);
            if ((m_fifo.size() > 0) && trace_ready) void'(m_fifo.pop_front());
            if (m_active && (m_t < m_n) && rwe && (rd != 0)) begin
                if (m_fifo.size() < TD) m_fifo.push_back('{m_t, int'(rd), rdata});
                else m_ovf = 1;
            end
            if (m_active && (m_t >= m_n) && (m_t < m_n + 2 * NR) && (((m_t - m_n) % 2) == 1)) begin
                i = (m_t - m_n) / 2;
                if (rom[i] !== regs[i]) begin
                    m_errq.push_back('{i, rom[i], regs[i]});
                    m_err++;
                end
            end
            if (start && !busy) begin
                m_active = 1; m_t = 0; m_n = int'(num_cycles); m_err = 0; m_ovf = 0;
                m_fifo.delete();
            end else if (m_active && (m_t < 1000000)) begin
                m_t++;
            end
        end
    end

    // Monitor: status levels every cycle, error pulses and trace pops against queues
    always @(negedge clock) begin
        bit  exp_tm, exp_done;
        er_t e;
        tr_t h;
        if (reset) begin
            exp_tm   = m_active && (m_t >= m_n);
            exp_done = m_active && (m_t >= m_n + 2 * NR);
            chk("test_mode", 64'(test_mode), 64'(exp_tm));
            chk("done", 64'(done), 64'(exp_done));
            chk("pass", 64'(pass), 64'(exp_done && (m_err == 0)));
            chk("error_count", 64'(error_count), 64'(m_err));
            chk("trace_overflow", 64'(trace_overflow), 64'(m_ovf));
            chk("trace_valid", 64'(trace_valid), 64'(m_fifo.size() > 0));
            if (exp_tm && !exp_done) chk("scan_addr", 64'(scan_addr), 64'((m_t - m_n) / 2));
            chk("err_valid", 64'(err_valid), 64'(m_errq.size() > 0));
            if (err_valid && (m_errq.size() > 0)) begin
                e = m_errq.pop_front();
                chk("err_reg", 64'(err_reg), 64'(e.r));
                chk("err_exp", 64'(err_exp), 64'(e.e));
                chk("err_act", 64'(err_act), 64'(e.a));
            end
            if (trace_valid && trace_ready && (m_fifo.size() > 0)) begin
                h = m_fifo[0];
                chk("trace_cycle", 64'(trace_cycle), 64'(h.cyc));
                chk("trace_reg", 64'(trace_reg), 64'(h.r));
                chk("trace_data", 64'(trace_data), 64'(h.d));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input int n);
        start = 1'b1;
        num_cycles = CW'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (!done && (k < limit)) begin
            tick();
            k++;
        end
        chk("wait_done", 64'(done), 64'(1));
    endtask

    task automatic drain();
        int k = 0;
        trace_ready = 1'b1;
        while (trace_valid && (k < 40)) begin
            tick();
            k++;
        end
        trace_ready = 1'b0;
        chk("drain_empty", 64'(trace_valid), 64'(0));
    endtask

    task automatic restore_arrays();
        for (int i = 0; i < NR; i++) begin
            regs[i] = DW'(i);
            rom[i]  = DW'(i);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; num_cycles = '0; rwe = 1'b0; rd = '0;
        rdata = '0; trace_ready = 1'b0;
        restore_arrays();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_test_mode", 64'(test_mode), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_trace_valid", 64'(trace_valid), 64'(0));
        chk("rst_error_count", 64'(error_count), 64'(0));
        reset = 1'b1;
        tick();

        // Directed trace: r3=7 @2, r0=9 @4 (skipped), r31=-1 @9
        pulse_start(10);
        for (int t = 0; t < 10; t++) begin
            rwe   = (t == 2) || (t == 4) || (t == 9);
            rd    = (t == 2) ? AW'(3) : ((t == 4) ? AW'(0) : AW'(31));
            rdata = (t == 2) ? DW'(7) : ((t == 4) ? DW'(9) : 32'hFFFF_FFFF);
            tick();
        end
        rwe = 1'b0;
        wait_done(2 * NR + 8);
        chk("t1_head_cyc", 64'(trace_cycle), 64'(2));
        chk("t1_head_reg", 64'(trace_reg), 64'(3));
        chk("t1_head_data", 64'(trace_data), 64'(7));
        trace_ready = 1'b1; tick(); trace_ready = 1'b0;
        chk("t1_second_cyc", 64'(trace_cycle), 64'(9));
        chk("t1_second_reg", 64'(trace_reg), 64'(31));
        chk("t1_second_data", 64'(trace_data), 64'(32'hFFFF_FFFF));
        trace_ready = 1'b1; tick(); trace_ready = 1'b0;
        chk("t1_empty", 64'(trace_valid), 64'(0));
        chk("t1_pass", 64'(pass), 64'(1));

        // Two injected mismatches
        regs[5] = 32'd6; rom[31] = 32'd0; regs[31] = 32'd1;
        pulse_start(3);
        wait_done(2 * NR + 8);
        chk("t2_error_count", 64'(error_count), 64'(2));
        chk("t2_pass", 64'(pass), 64'(0));
        restore_arrays();

        // Overflow: 6 writes into a 4-deep FIFO with no consumer
        pulse_start(8);
        for (int t = 0; t < 8; t++) begin
            rwe = (t < 6); rd = AW'(t + 1); rdata = $urandom;
            tick();
        end
        rwe = 1'b0;
        wait_done(2 * NR + 8);
        chk("t3_overflow", 64'(trace_overflow), 64'(1));
        drain();

        // Push while full together with a pop must not overflow
        pulse_start(8);
        for (int t = 0; t < 8; t++) begin
            rwe = (t < 5); rd = AW'(t + 10); rdata = $urandom;
            trace_ready = (t == 4);
            tick();
        end
        rwe = 1'b0; trace_ready = 1'b0;
        wait_done(2 * NR + 8);
        chk("t3b_overflow", 64'(trace_overflow), 64'(0));
        drain();

        // Zero budget, ignored mid-scan start, rerun from DONE
        pulse_start(0);
        chk("t4_test_mode", 64'(test_mode), 64'(1));
        repeat (10) tick();
        pulse_start(5);
        wait_done(2 * NR + 8);
        rom[7] = 32'hDEAD_0007;
        pulse_start(0);
        chk("t4_cnt_cleared", 64'(error_count), 64'(0));
        chk("t4_done_cleared", 64'(done), 64'(0));
        wait_done(2 * NR + 8);
        chk("t4_error_count", 64'(error_count), 64'(1));
        restore_arrays();

        // Randomized runs
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(0, 20);
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 1) == 1) regs[$urandom_range(0, NR - 1)] = $urandom;
            end
            pulse_start(n);
            for (int c = 0; c < n + 2 * NR + 4; c++) begin
                if (done) break;
                rwe = $urandom_range(0, 1) == 1;
                rd = AW'($urandom_range(0, NR - 1));
                rdata = $urandom;
                trace_ready = $urandom_range(0, 2) == 0;
                start = $urandom_range(0, 15) == 0;
                num_cycles = CW'($urandom_range(0, 20));
                tick();
            end
            rwe = 1'b0; start = 1'b0;
            chk("rand_done", 64'(done), 64'(1));
            drain();
            restore_arrays();
        end

        // Asynchronous reset in the middle of the sweep
        rom[11] = 32'hBAD0_000B;
        pulse_start(4);
        for (int t = 0; t < 4; t++) begin
            rwe = (t < 2); rd = AW'(t + 2); rdata = $urandom;
            tick();
        end
        rwe = 1'b0;
        for (int k = 0; k < 2 * NR; k++) begin
            if (test_mode && (scan_addr == AW'(12))) break;
            tick();
        end
        chk("t6_at_12", 64'(scan_addr), 64'(12));
        chk("t6_err_pre", 64'(err_valid), 64'(1));
        #1;
        reset = 1'b0;
        #1;
        chk("t6_test_mode", 64'(test_mode), 64'(0));
        chk("t6_done", 64'(done), 64'(0));
        chk("t6_err_valid", 64'(err_valid), 64'(0));
        chk("t6_trace_valid", 64'(trace_valid), 64'(0));
        chk("t6_error_count", 64'(error_count), 64'(0));
        restore_arrays();
        repeat (2) tick();
        reset = 1'b1;
        tick();
        pulse_start(0);
        chk("t6_restart", 64'(test_mode), 64'(1));
        wait_done(2 * NR + 8);
        chk("t6_pass", 64'(pass), 64'(1));
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_scan_checker.md
Name: regfile_scan_checker

Overview:
- Synthesizable, parametrised processor test harness placed beside the processor and regfile.
- Counts a programmed cycle budget and logs every register writeback into a trace FIFO.
- When the budget expires, takes over one regfile read port and sweeps all registers.
- Compares each register against an expected-value ROM and reports per-register mismatches, an error count and pass/done.

Parameters:
DATA_W, 32, register data width
NUM_REGS, 32, registers swept (2..256)
ADDR_W, $clog2(NUM_REGS), register index width
CYC_W, 16, cycle-budget and cycle-stamp width
TRACE_DEPTH, 16, trace FIFO entries (power of 2, >=2)
SKIP_R0, 1, 1 = never log writes to register 0

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state
start  in  1  one-cycle pulse, begins a run (accepted in IDLE or DONE only)
num_cycles  in  CYC_W  cycle budget, sampled on accepted start
rwe  in  1  observed regfile write enable
rd  in  ADDR_W  observed write register
rdata  in  DATA_W  observed write data
test_mode  out  1  1 = harness owns the read port (drives rs1 mux select)
scan_addr  out  ADDR_W  register index to read while test_mode=1
scan_data  in  DATA_W  regfile read data for scan_addr (combinational)
exp_addr  out  ADDR_W  expected-ROM address (synchronous ROM, 1-cycle latency)
exp_data  in  DATA_W  expected value
trace_valid  out  1  trace FIFO not empty
trace_ready  in  1  consumer pops head when valid&ready
trace_cycle  out  CYC_W  cycle stamp of head entry
trace_reg  out  ADDR_W  register of head entry
trace_data  out  DATA_W  data of head entry
trace_overflow  out  1  sticky, an entry was dropped
err_valid  out  1  one-cycle pulse, mismatch on err_reg
err_reg  out  ADDR_W  mismatching register
err_exp  out  DATA_W  expected value
err_act  out  DATA_W  actual value
error_count  out  ADDR_W+1  mismatches this run
done  out  1  level, sweep complete
pass  out  1  level, done & error_count==0

Behaviour:
- Reset (reset=0, async): state IDLE.
- Reset also clears: every output register, the cycle counter, the FIFO pointers and trace_overflow.
- Reset forces test_mode=0 immediately. Reset mid-run or mid-scan aborts with no further output.
- FSM states: IDLE, RUN, SCAN_ISSUE, SCAN_CMP, DONE.
- IDLE/DONE + start:
  - Latch num_cycles; clear error_count, done, pass and trace_overflow; flush the FIFO.
  - Go to RUN, or straight to SCAN_ISSUE if num_cycles==0.
- start in RUN, SCAN_ISSUE or SCAN_CMP is ignored.
- RUN:
  - Counter cyc goes 0..num_cycles-1, one per clock. Leave to SCAN_ISSUE after the cycle where cyc==num_cycles-1.
  - Each cycle with rwe=1, and rd!=0 when SKIP_R0=1, pushes {cyc, rd, rdata}.
  - FIFO full with no pop that cycle: entry dropped, trace_overflow set.
  - Full with a simultaneous pop: push accepted.
  - Empty FIFO: the pushed entry appears on trace_valid the next cycle (no fall-through).
- Writes are not logged outside RUN. The FIFO stays readable in all states except reset.
- test_mode=1 in SCAN_ISSUE, SCAN_CMP and DONE; 0 in IDLE and RUN.
- Scan index i starts at 0. scan_addr = exp_addr = i.
- SCAN_ISSUE: drive i; the ROM registers exp_data.
- SCAN_CMP:
  - Compare exp_data against scan_data, 4-state exact.
  - On mismatch: pulse err_valid with err_reg=i, err_exp and err_act; increment error_count.
  - If i==NUM_REGS-1 go to DONE, else i+1 and return to SCAN_ISSUE.
- Sweep takes exactly 2*NUM_REGS cycles. done rises the cycle after the last compare.
- DONE: done=1 and pass=(error_count==0), both held until the next accepted start or reset.
- error_count never wraps (max NUM_REGS fits in ADDR_W+1).

Decomposition:
- Shared package harness_pkg holds:
  - the state enum (IDLE, RUN, SCAN_ISSUE, SCAN_CMP, DONE);
  - the trace entry width constant TRACE_W = CYC_W+ADDR_W+DATA_W;
  - pack/unpack field offsets.
- One sub-module: trace_fifo, a synchronous FIFO with these parameters and ports:
  - parameters: WIDTH, DEPTH;
  - ports: push, pop, full, empty, flush and async active-low reset.
- The top level holds the FSM, the counters and the comparator.

Test Plan:
- num_cycles=10; writes of r3=7 (cyc 2), r0=9 (cyc 4), r31=-1 (cyc 9) -> trace holds exactly (2,3,7) and (9,31,0xFFFFFFFF); r0 absent; trace_overflow=0.
- Regfile and ROM both hold r_i=i -> after 2*32 scan cycles: done=1, pass=1, error_count=0, no err_valid pulse.
- ROM r5=5 but regfile r5=6, ROM r31=0 but regfile r31=1 -> err_valid pulses with (5,5,6) then (31,0,1); error_count=2; pass=0.
- TRACE_DEPTH=4, trace_ready=0, 6 logged writes -> first 4 retained in order; trace_overflow=1. A pop concurrent with a push while full must not set overflow.
- num_cycles=0 -> scan starts the cycle after start; start pulsed mid-scan is ignored; start in DONE reruns and clears error_count.
- reset driven low mid-scan at i=12 -> test_mode, done and err_valid go to 0 without waiting for a clock edge; FIFO empty; FSM in IDLE.
